// File: rtl/hazard_forward_if.sv
// Pipeline-to-hazard-unit signal bundle: EX/ID register fields in, forwarding and pipeline
// controls out. Perf counters exist only when HAZARD_PERF_EN is defined.
interface hazard_forward_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] if_id_rs1;
  logic [REG_AW-1:0] if_id_rs2;
  logic [REG_AW-1:0] id_ex_rs1;
  logic [REG_AW-1:0] id_ex_rs2;
  logic [REG_AW-1:0] id_ex_rd;
  logic              id_ex_regwrite;
  logic              id_ex_memread;
  logic              branch_taken;
  logic              mem_ready;

  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              pipe_freeze;
  logic              mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;
`endif

  // Pipeline side: drives register fields and status, consumes controls.
  modport master (
    output if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd,
    output id_ex_regwrite, id_ex_memread, branch_taken, mem_ready,
    input  forward_a, forward_b, pc_write, if_id_write, if_id_flush,
    input  id_ex_bubble, pipe_freeze, mem_timeout
`ifdef HAZARD_PERF_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd,
    input  id_ex_regwrite, id_ex_memread, branch_taken, mem_ready,
    output forward_a, forward_b, pc_write, if_id_write, if_id_flush,
    output id_ex_bubble, pipe_freeze, mem_timeout
`ifdef HAZARD_PERF_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Forwarding select, load-use stall, branch flush and memory-wait freeze control for a
// 5-stage pipeline. Define HAZARD_PERF_EN to add the stall/flush performance counters.
module hazard_forward_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 32
) (
  input logic             clk,
  input logic             reset,
  hazard_forward_if.slave bus
);
  localparam int unsigned WaitW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e            r_state;
  state_e            w_state_next;

  logic [REG_AW-1:0] r_em_rd;
  logic              r_em_rw;
  logic              r_em_mr;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_rw;

  logic [WaitW-1:0]  r_wait_cnt;
  logic [WaitW-1:0]  w_wait_cnt_next;
  logic [WaitW-1:0]  w_cnt_inc;
  logic              r_mem_timeout;
  logic              w_mem_timeout_next;

  logic              w_load_use;
  logic              w_freeze;
  logic              w_pc_write;
  logic              w_if_id_write;
  logic              w_if_id_flush;
  logic              w_id_ex_bubble;

  // EX/MEM beats MEM/WB; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] em_rd,
    input logic              em_rw,
    input logic [REG_AW-1:0] wb_rd,
    input logic              wb_rw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (em_rw && (em_rd != '0) && (em_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_rw && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_load_use = bus.id_ex_memread && (bus.id_ex_rd != '0) &&
                      ((bus.id_ex_rd == bus.if_id_rs1) || (bus.id_ex_rd == bus.if_id_rs2));

  assign w_cnt_inc = r_wait_cnt + WaitW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_em_rd <= '0;
      r_em_rw <= 1'b0;
      r_em_mr <= 1'b0;
      r_wb_rd <= '0;
      r_wb_rw <= 1'b0;
    end else if (!w_freeze) begin
      r_em_rd <= bus.id_ex_rd;
      r_em_rw <= bus.id_ex_regwrite;
      r_em_mr <= bus.id_ex_memread;
      r_wb_rd <= r_em_rd;
      r_wb_rw <= r_em_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StRun;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_mem_timeout <= w_mem_timeout_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_wait_cnt_next    = r_wait_cnt;
    w_mem_timeout_next = r_mem_timeout;
    w_freeze           = 1'b0;
    w_pc_write         = 1'b1;
    w_if_id_write      = 1'b1;
    w_if_id_flush      = 1'b0;
    w_id_ex_bubble     = 1'b0;

    unique case (r_state)
      StRun: begin
        w_wait_cnt_next = '0;
        if (r_em_mr && !bus.mem_ready) begin
          // Freeze starts in the detecting cycle so MEM never loses the access.
          w_freeze      = 1'b1;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_state_next  = StMemWait;
        end else if (bus.branch_taken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (w_load_use) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
        end
      end

      StMemWait: begin
        w_freeze        = 1'b1;
        w_pc_write      = 1'b0;
        w_if_id_write   = 1'b0;
        w_wait_cnt_next = w_cnt_inc;
        if (bus.mem_ready) begin
          w_state_next    = StRun;
          w_wait_cnt_next = '0;
        end else if (w_cnt_inc >= WaitW'(MAX_WAIT)) begin
          w_mem_timeout_next = 1'b1;
          w_state_next       = StRun;
          w_wait_cnt_next    = '0;
        end
      end

      default: begin
        w_state_next    = StRun;
        w_wait_cnt_next = '0;
      end
    endcase
  end

  assign bus.forward_a    = fwd_sel(bus.id_ex_rs1, r_em_rd, r_em_rw, r_wb_rd, r_wb_rw);
  assign bus.forward_b    = fwd_sel(bus.id_ex_rs2, r_em_rd, r_em_rw, r_wb_rd, r_wb_rw);
  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.pipe_freeze  = w_freeze;
  assign bus.mem_timeout  = r_mem_timeout;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_pc_write) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_if_id_flush) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`endif
endmodule
